// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: ALU ops, opcodes,
// functs, FSM states, datapath select codes and the registered control bundle.
package mips_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_ORI  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_ANDI = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1101;
  localparam logic [3:0] ALU_JMP  = 4'b1110;
  localparam logic [3:0] ALU_JAL  = 4'b1111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL
  } instr_class_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  // Input-independent part of the control word for a given state; the
  // handshake and branch-condition terms are merged in by the FSM.
  function automatic ctrl_t moore_ctrl(input state_t st, input logic [3:0] op,
                                       input instr_class_t cls);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM;
      S_MEM_ADDR, S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = op;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = op;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = op;
        c.pc_source = PCSRC_BRANCH;
      end
      S_MEM_READ:  c.mem_read = 1'b1;
      S_MEM_WRITE: c.mem_write = 1'b1;
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = M2R_MEM;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_RD;
        c.mem_to_reg = M2R_ALU;
      end
      S_I_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = M2R_ALU;
      end
      S_JUMP: begin
        c.alu_op    = op;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
        if (cls == CLS_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = REGDST_R31;
          c.mem_to_reg = M2R_PC;
        end
      end
      default: c = c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_op_decode.sv
// Combinational instruction decode: opcode/funct -> ALU op, instruction class
// and an illegal flag for anything outside the supported subset.
module mips_op_decode
  import mips_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output logic [3:0]   op_o,
  output instr_class_t cls_o,
  output logic         illegal_o
);

  always_comb begin
    op_o      = ALU_ADD;
    cls_o     = CLS_NOP;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        cls_o = CLS_R;
        case (funct_i)
          FN_ADD: op_o = ALU_ADD;
          FN_SUB: op_o = ALU_SUB;
          FN_AND: op_o = ALU_AND;
          FN_OR:  op_o = ALU_OR;
          FN_NOR: op_o = ALU_NOR;
          FN_SLL: op_o = ALU_SLL;
          FN_SRL: op_o = ALU_SRL;
          default: begin
            cls_o     = CLS_NOP;
            illegal_o = 1'b1;
          end
        endcase
      end
      OPC_ADDI: begin cls_o = CLS_I;   op_o = ALU_ADD;  end
      OPC_ANDI: begin cls_o = CLS_I;   op_o = ALU_ANDI; end
      OPC_ORI:  begin cls_o = CLS_I;   op_o = ALU_ORI;  end
      OPC_LUI:  begin cls_o = CLS_I;   op_o = ALU_LUI;  end
      OPC_LW:   begin cls_o = CLS_LW;  op_o = ALU_ADD;  end
      OPC_SW:   begin cls_o = CLS_SW;  op_o = ALU_ADD;  end
      OPC_BEQ:  begin cls_o = CLS_BEQ; op_o = ALU_SUB;  end
      OPC_BNE:  begin cls_o = CLS_BNE; op_o = ALU_SUB;  end
      OPC_J:    begin cls_o = CLS_J;   op_o = ALU_JMP;  end
      OPC_JAL:  begin cls_o = CLS_JAL; op_o = ALU_JAL;  end
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM. Define MC_ILLEGAL_TRAP_EN to park unsupported
// instructions in TRAP; otherwise they retire as NOPs.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int OP_W = 4,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      opcode_i,
  input  logic [5:0]      funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic [OP_W-1:0] alu_operation_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic            pc_write_o,
  output logic [1:0]      pc_source_o,
  output logic            ir_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            reg_write_o,
  output logic [1:0]      reg_dst_o,
  output logic [1:0]      mem_to_reg_o,
  output logic [ST_W-1:0] state_o,
  output logic            illegal_o
);

  logic [3:0]   w_dec_op;
  instr_class_t w_dec_cls;
  logic         w_dec_illegal;

  state_t       r_state, w_state_next;
  logic [3:0]   r_op, w_op_next;
  instr_class_t r_cls, w_cls_next;
  ctrl_t        r_ctrl;
  logic         w_in_fetch, w_in_branch, w_branch_taken;

  mips_op_decode u_decode (
    .opcode_i  (opcode_i),
    .funct_i   (funct_i),
    .op_o      (w_dec_op),
    .cls_o     (w_dec_cls),
    .illegal_o (w_dec_illegal)
  );

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_cls_next   = r_cls;
    case (r_state)
      S_FETCH: if (mem_ready_i) w_state_next = S_DECODE;
      S_DECODE: begin
        w_op_next  = w_dec_op;
        w_cls_next = w_dec_cls;
        if (w_dec_illegal) begin
`ifdef MC_ILLEGAL_TRAP_EN
          w_state_next = S_TRAP;
`else
          w_state_next = S_FETCH;
`endif
        end else begin
          case (w_dec_cls)
            CLS_R:            w_state_next = S_EXEC_R;
            CLS_I:            w_state_next = S_EXEC_I;
            CLS_LW, CLS_SW:   w_state_next = S_MEM_ADDR;
            CLS_BEQ, CLS_BNE: w_state_next = S_BRANCH;
            CLS_J, CLS_JAL:   w_state_next = S_JUMP;
            default:          w_state_next = S_FETCH;
          endcase
        end
      end
      S_MEM_ADDR:  w_state_next = (r_cls == CLS_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready_i) w_state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready_i) w_state_next = S_FETCH;
      S_EXEC_R:    w_state_next = S_R_WB;
      S_EXEC_I:    w_state_next = S_I_WB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:      w_state_next = S_TRAP;
`endif
      default:     w_state_next = S_FETCH;
    endcase
  end

  // The control word is registered from the next state so it lines up with
  // the state it belongs to; reset loads the FETCH word directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= ALU_ADD;
      r_cls   <= CLS_NOP;
      r_ctrl  <= moore_ctrl(S_FETCH, ALU_ADD, CLS_NOP);
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;
      r_cls   <= w_cls_next;
      r_ctrl  <= moore_ctrl(w_state_next, w_op_next, w_cls_next);
    end
  end

  assign w_in_fetch     = (r_state == S_FETCH);
  assign w_in_branch    = (r_state == S_BRANCH);
  assign w_branch_taken = (r_cls == CLS_BNE) ? ~zero_i : zero_i;

  assign alu_operation_o = OP_W'(r_ctrl.alu_op);
  assign alu_src_a_o     = r_ctrl.alu_src_a;
  assign alu_src_b_o     = r_ctrl.alu_src_b;
  assign pc_write_o      = r_ctrl.pc_write | (w_in_fetch & mem_ready_i)
                         | (w_in_branch & w_branch_taken);
  assign pc_source_o     = r_ctrl.pc_source;
  assign ir_write_o      = w_in_fetch & mem_ready_i;
  assign mem_read_o      = r_ctrl.mem_read;
  assign mem_write_o     = r_ctrl.mem_write;
  assign reg_write_o     = r_ctrl.reg_write;
  assign reg_dst_o       = r_ctrl.reg_dst;
  assign mem_to_reg_o    = r_ctrl.mem_to_reg;
  assign state_o         = ST_W'(r_state);

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_o = (r_state == S_TRAP);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: directed scenarios plus random instruction
// streams, checked every cycle against an instruction-level step model.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       reset, zero_i, mem_ready_i;
  logic [5:0] opcode_i, funct_i;
  logic [3:0] alu_operation_o;
  logic       alu_src_a_o, pc_write_o, ir_write_o, mem_read_o, mem_write_o;
  logic       reg_write_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o, reg_dst_o, mem_to_reg_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .alu_operation_o(alu_operation_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .pc_write_o(pc_write_o),
    .pc_source_o(pc_source_o), .ir_write_o(ir_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .state_o(state_o), .illegal_o(illegal_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;

  // Model: current step number, remaining steps of the instruction, latched op.
  int         m_st  = 0;
  int         m_opq = 0;
  int         m_path[$];
  logic [5:0] cur_op = 6'h00, cur_fn = 6'h00;
  logic [5:0] nxt_op = 6'h00, nxt_fn = 6'h20;

  // ALU op of an instruction from the decode table; -1 when unsupported.
  function automatic int spec_op(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'h00: case (fn)
        6'h20: return 0;  6'h22: return 1;  6'h24: return 13;
        6'h25: return 2;  6'h27: return 12; 6'h00: return 5;
        6'h02: return 4;  default: return -1;
      endcase
      6'h08: return 0;  6'h0C: return 7;  6'h0D: return 3;  6'h0F: return 6;
      6'h23: return 0;  6'h2B: return 0;  6'h04: return 1;  6'h05: return 1;
      6'h02: return 14; 6'h03: return 15;
      default: return -1;
    endcase
  endfunction

  task automatic build_path(input logic [5:0] opc, input logic [5:0] fn);
    m_path.delete();
    m_path.push_back(1);
    if (spec_op(opc, fn) < 0) begin
`ifdef MC_ILLEGAL_TRAP_EN
      m_path.push_back(12);
`endif
    end else begin
      case (opc)
        6'h00: begin m_path.push_back(6); m_path.push_back(7); end
        6'h23: begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
        6'h2B: begin m_path.push_back(2); m_path.push_back(5); end
        6'h04, 6'h05: m_path.push_back(10);
        6'h02, 6'h03: m_path.push_back(11);
        default: begin m_path.push_back(8); m_path.push_back(9); end
      endcase
    end
  endtask

  task automatic pop_step(output int s);
    if (m_path.size() > 0) s = m_path.pop_front();
    else s = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int  e_op, e_srcb, e_pcw, e_pcs, e_rdst, e_m2r;
    bit  jal;
    jal  = (m_st == 11) && (cur_op == 6'h03);
    e_op = (m_st inside {2, 6, 8, 10, 11}) ? m_opq : 0;
    case (m_st)
      0: e_srcb = 1;
      1, 2, 8: e_srcb = 2;
      default: e_srcb = 0;
    endcase
    case (m_st)
      0:  e_pcw = int'(mem_ready_i);
      10: e_pcw = (cur_op == 6'h05) ? int'(!zero_i) : int'(zero_i);
      11: e_pcw = 1;
      default: e_pcw = 0;
    endcase
    e_pcs  = (m_st == 10) ? 1 : (m_st == 11) ? 2 : 0;
    e_rdst = (m_st == 7) ? 1 : jal ? 2 : 0;
    e_m2r  = (m_st == 4) ? 1 : jal ? 2 : 0;
    chk("state", int'(state_o), m_st);
    chk("alu_op", int'(alu_operation_o), e_op);
    chk("src_a", int'(alu_src_a_o), int'(m_st inside {2, 6, 8, 10}));
    chk("src_b", int'(alu_src_b_o), e_srcb);
    chk("pc_write", int'(pc_write_o), e_pcw);
    chk("pc_source", int'(pc_source_o), e_pcs);
    chk("ir_write", int'(ir_write_o), int'(m_st == 0 && mem_ready_i));
    chk("mem_read", int'(mem_read_o), int'(m_st == 0 || m_st == 3));
    chk("mem_write", int'(mem_write_o), int'(m_st == 5));
    chk("reg_write", int'(reg_write_o), int'(m_st inside {4, 7, 9} || jal));
    chk("reg_dst", int'(reg_dst_o), e_rdst);
    chk("mem_to_reg", int'(mem_to_reg_o), e_m2r);
    chk("illegal", int'(illegal_o), int'(m_st == 12));
    chk("rd_wr_excl", int'(mem_read_o & mem_write_o), 0);
  endtask

  task automatic model_update();
    int s;
    if (reset) begin
      m_st = 0; m_opq = 0; m_path.delete();
    end else begin
      case (m_st)
        0: if (mem_ready_i) begin
          cur_op = nxt_op; cur_fn = nxt_fn; n_instr++;
          $display("instr %0d: opcode=%02h funct=%02h", n_instr, cur_op, cur_fn);
          build_path(cur_op, cur_fn);
          pop_step(s); m_st = s;
        end
        3, 5: if (mem_ready_i) begin pop_step(s); m_st = s; end
        12: m_st = 12;
        1: begin
          if (spec_op(cur_op, cur_fn) >= 0) m_opq = spec_op(cur_op, cur_fn);
          pop_step(s); m_st = s;
        end
        default: begin pop_step(s); m_st = s; end
      endcase
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic z);
    reset = rst; mem_ready_i = rdy; zero_i = z;
    @(negedge clk);
    compare_model();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
    opcode_i = cur_op; funct_i = cur_fn;
  endtask

  task automatic to_exec(input logic [5:0] opc, input logic [5:0] fn);
    nxt_op = opc; nxt_fn = fn;
    drive(0, 1, 0); adv();
    drive(0, 1, 0); adv();
  endtask

  logic [5:0] ops_tbl[12];
  logic [5:0] fn_tbl[8];

  initial begin
    int trap_cnt;
    logic rst, rdy;
    ops_tbl = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    fn_tbl  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h3F};
    reset = 1'b1; mem_ready_i = 1'b0; zero_i = 1'b0;
    opcode_i = 6'h00; funct_i = 6'h00;
    @(posedge clk); #1;

    drive(1, 0, 0); chk("reset_state", int'(state_o), 0);
    chk("reset_op", int'(alu_operation_o), 0); adv();

    // add: 0,1,6,7,0
    nxt_op = 6'h00; nxt_fn = 6'h20;
    drive(0, 1, 0); chk("add_fetch", int'(state_o), 0); adv();
    drive(0, 1, 0); chk("add_decode", int'(state_o), 1); adv();
    drive(0, 1, 0); chk("add_exec", int'(state_o), 6);
    chk("add_exec_op", int'(alu_operation_o), 0); adv();
    drive(0, 1, 0); chk("add_wb", int'(state_o), 7);
    chk("add_wb_rw", int'(reg_write_o), 1); chk("add_wb_dst", int'(reg_dst_o), 1); adv();
    drive(0, 0, 0); chk("add_back", int'(state_o), 0); adv();

    // lw with a stalled read
    to_exec(6'h23, 6'h00);
    drive(0, 1, 0); chk("lw_addr", int'(state_o), 2); adv();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0); chk("lw_hold", int'(state_o), 3);
      chk("lw_hold_rd", int'(mem_read_o), 1); adv();
    end
    drive(0, 1, 0); chk("lw_done", int'(state_o), 3); adv();
    drive(0, 1, 0); chk("lw_wb", int'(state_o), 4);
    chk("lw_wb_m2r", int'(mem_to_reg_o), 1); adv();

    // branches
    to_exec(6'h04, 6'h00); drive(0, 1, 1);
    chk("beq_t_pcw", int'(pc_write_o), 1); chk("beq_t_pcs", int'(pc_source_o), 1); adv();
    to_exec(6'h04, 6'h00); drive(0, 1, 0); chk("beq_nt_pcw", int'(pc_write_o), 0); adv();
    to_exec(6'h05, 6'h00); drive(0, 1, 0); chk("bne_t_pcw", int'(pc_write_o), 1); adv();
    to_exec(6'h05, 6'h00); drive(0, 1, 1); chk("bne_nt_pcw", int'(pc_write_o), 0); adv();

    // jal
    to_exec(6'h03, 6'h00); drive(0, 1, 0);
    chk("jal_state", int'(state_o), 11); chk("jal_op", int'(alu_operation_o), 15);
    chk("jal_pcw", int'(pc_write_o), 1); chk("jal_pcs", int'(pc_source_o), 2);
    chk("jal_rw", int'(reg_write_o), 1); chk("jal_dst", int'(reg_dst_o), 2);
    chk("jal_m2r", int'(mem_to_reg_o), 2); adv();

    // reset during a stalled store
    to_exec(6'h2B, 6'h00);
    drive(0, 1, 0); adv();
    drive(0, 0, 0); chk("sw_write", int'(mem_write_o), 1); adv();
    drive(1, 0, 0); adv();
    drive(0, 0, 0); chk("sw_rst_state", int'(state_o), 0);
    chk("sw_rst_mw", int'(mem_write_o), 0); chk("sw_rst_op", int'(alu_operation_o), 0); adv();

    // unsupported opcode
    to_exec(6'h3F, 6'h00);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0); chk("ill_trap", int'(state_o), 12);
      chk("ill_flag", int'(illegal_o), 1); adv();
    end
    drive(1, 0, 0); adv();
`else
    drive(0, 0, 0); chk("ill_nop", int'(state_o), 0);
    chk("ill_rw", int'(reg_write_o), 0); adv();
`endif

    // random instruction streams
    trap_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (m_st == 0) begin
        nxt_op = ops_tbl[$urandom_range(0, 11)];
        if ($urandom_range(0, 15) == 0) nxt_op = 6'($urandom_range(0, 63));
        nxt_fn = fn_tbl[$urandom_range(0, 7)];
      end
      trap_cnt = (m_st == 12) ? trap_cnt + 1 : 0;
      rst = ($urandom_range(0, 199) == 0) || (trap_cnt > 3);
      rdy = ($urandom_range(0, 9) < 7);
      drive(rst, rdy, 1'($urandom_range(0, 1)));
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
